// File: rtl/usbf_wb_master_if.sv
// Command/response streams and Wishbone initiator signals of usbf_wb_master.
// The "master" modport is the initiator's own view; "slave" is the view of its surroundings.
`ifndef USBF_UFC_HADR
`define USBF_UFC_HADR 17
`endif

interface usbf_wb_master_if;
    localparam int AddrW = `USBF_UFC_HADR + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [AddrW-1:0] cmd_addr;
    logic [31:0]      cmd_wdata;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_we;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;

    logic [AddrW-1:0] wb_addr_o;
    logic [31:0]      wb_data_o;
    logic [31:0]      wb_data_i;
    logic             wb_ack_i;
    logic             wb_we_o;
    logic             wb_stb_o;
    logic             wb_cyc_o;

    logic             busy;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, wb_data_i, wb_ack_i,
        output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
        output wb_addr_o, wb_data_o, wb_we_o, wb_stb_o, wb_cyc_o, busy
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, wb_data_i, wb_ack_i,
        input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
        input  wb_addr_o, wb_data_o, wb_we_o, wb_stb_o, wb_cyc_o, busy
    );
endinterface

// File: rtl/usbf_wb_master.sv
// Wishbone classic initiator fed by a command FIFO; one response per command.
// Define USBF_WBM_TIMEOUT_EN to abort unacknowledged cycles after TIMEOUT clocks.
`ifndef USBF_UFC_HADR
`define USBF_UFC_HADR 17
`endif

module usbf_wb_master #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    usbf_wb_master_if.master bus
);
    localparam int AddrW = `USBF_UFC_HADR + 1;
    localparam int PtrW  = $clog2(CMD_DEPTH);
    localparam int CntW  = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(CMD_DEPTH);

    typedef struct packed {
        logic             we;
        logic [AddrW-1:0] addr;
        logic [31:0]      wdata;
    } cmdEntry_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    cmdEntry_t        cmdMem [CMD_DEPTH];
    cmdEntry_t        head;
    logic [PtrW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             cmdReady_q;
    logic             push, pop;

    state_t           state_q;
    logic [AddrW-1:0] wbAddr_q;
    logic [31:0]      wbData_q;
    logic             wbWe_q, wbCyc_q, wbStb_q;
    logic             rspValid_q, rspWe_q;
    logic [31:0]      rspRdata_q;

`ifdef USBF_WBM_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
    logic [15:0]      timeoutCnt_q;
    logic             rspErr_q;
`endif

    // The head is popped on the same edge the FSM leaves IDLE with it.
    assign push = bus.cmd_valid & cmdReady_q;
    assign pop  = (state_q == IDLE) && (count_q != '0);
    assign head = cmdMem[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) wrPtr_d = wrPtr_q + PtrW'(1);
        if (pop)  rdPtr_d = rdPtr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            cmdReady_q <= 1'b1;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            cmdReady_q <= (count_d != FullCount);
        end
    end

    always_ff @(posedge clk) begin
        if (push) cmdMem[wrPtr_q] <= '{we: bus.cmd_we, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    end

    // Ack wins over an expiring timeout; ack is only looked at while in BUS.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wbAddr_q   <= '0;
            wbData_q   <= '0;
            wbWe_q     <= 1'b0;
            wbCyc_q    <= 1'b0;
            wbStb_q    <= 1'b0;
            rspValid_q <= 1'b0;
            rspWe_q    <= 1'b0;
            rspRdata_q <= '0;
`ifdef USBF_WBM_TIMEOUT_EN
            rspErr_q     <= 1'b0;
            timeoutCnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        wbAddr_q <= head.addr;
                        wbData_q <= head.wdata;
                        wbWe_q   <= head.we;
                        wbCyc_q  <= 1'b1;
                        wbStb_q  <= 1'b1;
                        state_q  <= BUS;
`ifdef USBF_WBM_TIMEOUT_EN
                        timeoutCnt_q <= '0;
`endif
                    end
                end
                BUS: begin
                    if (bus.wb_ack_i) begin
                        rspRdata_q <= wbWe_q ? 32'h0 : bus.wb_data_i;
                        rspWe_q    <= wbWe_q;
                        rspValid_q <= 1'b1;
                        wbCyc_q    <= 1'b0;
                        wbStb_q    <= 1'b0;
                        state_q    <= RESP;
`ifdef USBF_WBM_TIMEOUT_EN
                        rspErr_q   <= 1'b0;
                    end else if (timeoutCnt_q == TimeoutLast) begin
                        rspRdata_q <= 32'h0;
                        rspWe_q    <= wbWe_q;
                        rspErr_q   <= 1'b1;
                        rspValid_q <= 1'b1;
                        wbCyc_q    <= 1'b0;
                        wbStb_q    <= 1'b0;
                        state_q    <= RESP;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 16'd1;
`endif
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmdReady_q;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_we    = rspWe_q;
    assign bus.rsp_rdata = rspRdata_q;
    assign bus.wb_addr_o = wbAddr_q;
    assign bus.wb_data_o = wbData_q;
    assign bus.wb_we_o   = wbWe_q;
    assign bus.wb_cyc_o  = wbCyc_q;
    assign bus.wb_stb_o  = wbStb_q;
    assign bus.busy      = (count_q != '0) || (state_q != IDLE);

`ifdef USBF_WBM_TIMEOUT_EN
    assign bus.rsp_err = rspErr_q;
`else
    // Without the timeout the limit has no meaning; it is only sunk here.
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT != 0);
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_usbf_wb_master.sv
// Self-checking bench for usbf_wb_master: vector table, random traffic against a
// queue-based reference model, plus back-pressure, hold, timeout and reset sequences.
`ifndef USBF_UFC_HADR
`define USBF_UFC_HADR 17
`endif

module tb_usbf_wb_master;
    localparam int AddrW = `USBF_UFC_HADR + 1;
    localparam int Depth = 4;
    localparam int TimeoutCycles = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usbf_wb_master_if bus();

    usbf_wb_master #(.CMD_DEPTH(Depth), .TIMEOUT(TimeoutCycles)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic we; logic [AddrW-1:0] addr; logic [31:0] wdata; } busTxn_t;
    typedef struct { logic we; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct {
        logic we; logic [AddrW-1:0] addr; logic [31:0] wdata;
        int waitCyc; logic [31:0] expRdata; int expStbLen; int expLatency;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cycle = 0;

    busTxn_t expBusQ[$];
    rsp_t    expRspQ[$];
    logic [31:0] refMem [8];
    logic [31:0] slaveMem [8];

    int fixedWait = 0;
    bit ackEnable = 1'b1;
    bit noiseAck = 1'b0;
    bit holdLow = 1'b0;
    bit randReady = 1'b0;

    int rspCount = 0;
    int stbStarts = 0;
    int lastStbLen = 0;
    int lastLatency = 0;
    int lastPushCycle = 0;
    logic [31:0] lastRdata = 32'h0;
    logic lastWe = 1'b0;
    logic lastErr = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: commands complete in order against a plain word memory.
    task automatic modelPush(input logic we, input logic [AddrW-1:0] addr, input logic [31:0] wdata,
                             input bit expTimeout);
        busTxn_t b;
        rsp_t r;
        b.we = we; b.addr = addr; b.wdata = wdata;
        expBusQ.push_back(b);
        r.we = we; r.err = expTimeout; r.rdata = 32'h0;
        if (!expTimeout) begin
            if (we) refMem[addr[4:2]] = wdata;
            else r.rdata = refMem[addr[4:2]];
        end
        expRspQ.push_back(r);
    endtask

    task automatic applyStimulus(input logic we, input logic [AddrW-1:0] addr, input logic [31:0] wdata,
                                 input bit expTimeout);
        int n = 0;
        bus.cmd_we = we;
        bus.cmd_addr = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checkOutput("cmd_accept", 64'(bus.cmd_ready), 64'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        modelPush(we, addr, wdata, expTimeout);
        @(negedge clk);
        lastPushCycle = cycle;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitResponses(input int target, input string name);
        int n = 0;
        while (rspCount < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (rspCount < target) checkOutput(name, 64'(rspCount), 64'(target));
    endtask

    // Response side: owns rsp_ready, checks stability while waiting and scores each response.
    initial begin
        bit inResp = 1'b0;
        int firstSeen = 0;
        logic [33:0] snap = '0;
        rsp_t e;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (!inResp) begin
                    inResp = 1'b1;
                    firstSeen = cycle;
                    snap = {bus.rsp_we, bus.rsp_rdata, bus.rsp_err};
                end else begin
                    checkOutput("rsp_stable", 64'({bus.rsp_we, bus.rsp_rdata, bus.rsp_err}), 64'(snap));
                end
            end else begin
                inResp = 1'b0;
            end
            bus.rsp_ready = holdLow ? 1'b0 : (randReady ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (bus.rsp_valid && bus.rsp_ready) begin
                lastLatency = firstSeen - lastPushCycle;
                lastRdata = bus.rsp_rdata;
                lastWe = bus.rsp_we;
                lastErr = bus.rsp_err;
                if (expRspQ.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = expRspQ.pop_front();
                    checkOutput("rsp_we", 64'(bus.rsp_we), 64'(e.we));
                    checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    checkOutput("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                end
                rspCount++;
                inResp = 1'b0;
            end
        end
    end

    // Wishbone slave: word memory, programmable wait states, optional ack noise when idle.
    initial begin
        int stbCount = 0;
        int curWait = 0;
        busTxn_t snapB;
        busTxn_t e;
        bus.wb_ack_i = 1'b0;
        bus.wb_data_i = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.wb_cyc_o && bus.wb_stb_o) begin
                if (stbCount == 0) begin
                    stbStarts++;
                    curWait = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
                    snapB.we = bus.wb_we_o; snapB.addr = bus.wb_addr_o; snapB.wdata = bus.wb_data_o;
                    if (expBusQ.size() == 0) begin
                        checkOutput("bus_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = expBusQ.pop_front();
                        checkOutput("bus_we", 64'(bus.wb_we_o), 64'(e.we));
                        checkOutput("bus_addr", 64'(bus.wb_addr_o), 64'(e.addr));
                        if (e.we) checkOutput("bus_wdata", 64'(bus.wb_data_o), 64'(e.wdata));
                    end
                end else begin
                    checkOutput("bus_stable", 64'({bus.wb_we_o, bus.wb_addr_o, bus.wb_data_o}),
                                64'({snapB.we, snapB.addr, snapB.wdata}));
                end
                if (ackEnable && stbCount >= curWait) begin
                    bus.wb_ack_i = 1'b1;
                    if (bus.wb_we_o) begin
                        slaveMem[bus.wb_addr_o[4:2]] = bus.wb_data_o;
                        bus.wb_data_i = $urandom;
                    end else begin
                        bus.wb_data_i = slaveMem[bus.wb_addr_o[4:2]];
                    end
                    lastStbLen = stbCount + 1;
                end else begin
                    bus.wb_ack_i = 1'b0;
                    bus.wb_data_i = $urandom;
                end
                stbCount++;
            end else begin
                stbCount = 0;
                bus.wb_ack_i = noiseAck ? ($urandom_range(0, 1) == 1) : 1'b0;
                bus.wb_data_i = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int start;
        int accepted;
        int s0;
        int n;

        vecs[0] = '{1'b1, AddrW'(4),  32'h0000_00A5, 2, 32'h0,         3, 4};
        vecs[1] = '{1'b1, AddrW'(8),  32'hDEAD_BEEF, 0, 32'h0,         1, 2};
        vecs[2] = '{1'b0, AddrW'(8),  32'h0,         0, 32'hDEAD_BEEF, 1, 2};
        vecs[3] = '{1'b0, AddrW'(4),  32'h0,         1, 32'h0000_00A5, 2, 3};
        vecs[4] = '{1'b1, AddrW'(4),  32'h1234_5678, 3, 32'h0,         4, 5};
        vecs[5] = '{1'b0, AddrW'(4),  32'h0BAD_F00D, 0, 32'h1234_5678, 1, 2};

        for (int i = 0; i < 8; i++) begin
            refMem[i] = 32'h1000_0000 + 32'(i);
            slaveMem[i] = 32'h1000_0000 + 32'(i);
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_wdata = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_we", 64'(bus.rsp_we), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        checkOutput("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        checkOutput("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
        checkOutput("rst_stb", 64'(bus.wb_stb_o), 64'd0);
        checkOutput("rst_we", 64'(bus.wb_we_o), 64'd0);
        checkOutput("rst_addr", 64'(bus.wb_addr_o), 64'd0);
        checkOutput("rst_data", 64'(bus.wb_data_o), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            fixedWait = vecs[i].waitCyc;
            start = rspCount;
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
            waitResponses(start + 1, "tbl_rsp_wait");
            checkOutput("tbl_rdata", 64'(lastRdata), 64'(vecs[i].expRdata));
            checkOutput("tbl_rsp_we", 64'(lastWe), 64'(vecs[i].we));
            checkOutput("tbl_stb_len", 64'(lastStbLen), 64'(vecs[i].expStbLen));
            checkOutput("tbl_latency", 64'(lastLatency), 64'(vecs[i].expLatency));
        end
        repeat (2) @(negedge clk);
        checkOutput("wb_data_hold", 64'(bus.wb_data_o), 64'(vecs[5].wdata));
        checkOutput("idle_busy", 64'(bus.busy), 64'd0);

        $display("[TB] back-pressure");
        ackEnable = 1'b0;
        fixedWait = 0;
        accepted = 0;
        start = rspCount;
        for (int c = 0; c < 12; c++) begin
            if (bus.cmd_ready && accepted < 8) begin
                bus.cmd_we = (accepted % 2 == 0);
                bus.cmd_addr = AddrW'((accepted % 4) * 4);
                bus.cmd_wdata = 32'hB000_0000 + 32'(accepted);
                bus.cmd_valid = 1'b1;
                modelPush(bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, 1'b0);
                accepted++;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checkOutput("bp_accepted", 64'(accepted), 64'(Depth + 1));
        checkOutput("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        checkOutput("bp_busy", 64'(bus.busy), 64'd1);
        checkOutput("bp_stb", 64'(bus.wb_stb_o), 64'd1);
        ackEnable = 1'b1;
        waitResponses(start + Depth + 1, "bp_rsp_wait");
        checkOutput("bp_drained", 64'(expRspQ.size()), 64'd0);

        $display("[TB] response hold");
        holdLow = 1'b1;
        fixedWait = 1;
        start = rspCount;
        applyStimulus(1'b0, AddrW'(8), 32'h0, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
        applyStimulus(1'b1, AddrW'(12), 32'h5A5A_0000, 1'b0);
        s0 = stbStarts;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold_stb", 64'(bus.wb_stb_o), 64'd0);
            checkOutput("hold_valid", 64'(bus.rsp_valid), 64'd1);
        end
        checkOutput("hold_no_new_stb", 64'(stbStarts), 64'(s0));
        holdLow = 1'b0;
        waitResponses(start + 2, "hold_rsp_wait");

        $display("[TB] random traffic");
        randReady = 1'b1;
        fixedWait = -1;
        noiseAck = 1'b1;
        start = rspCount;
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, AddrW'($urandom_range(0, 7) * 4), $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitResponses(start + 40, "rand_rsp_wait");
        noiseAck = 1'b0;
        randReady = 1'b0;
        checkOutput("rand_rsp_drained", 64'(expRspQ.size()), 64'd0);
        checkOutput("rand_bus_drained", 64'(expBusQ.size()), 64'd0);

`ifdef USBF_WBM_TIMEOUT_EN
        $display("[TB] timeout");
        ackEnable = 1'b0;
        fixedWait = 0;
        start = rspCount;
        applyStimulus(1'b0, AddrW'(16), 32'h0, 1'b1);
        n = 0;
        while (!bus.wb_stb_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.wb_stb_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        checkOutput("to_stb_len", 64'(n), 64'(TimeoutCycles));
        waitResponses(start + 1, "to_rsp_wait");
        checkOutput("to_err", 64'(lastErr), 64'd1);
        ackEnable = 1'b1;
        applyStimulus(1'b1, AddrW'(16), 32'hC0FF_EE00, 1'b0);
        waitResponses(start + 2, "to_next_wait");
        checkOutput("to_next_err", 64'(lastErr), 64'd0);
`endif

        $display("[TB] reset during bus cycle");
        ackEnable = 1'b0;
        fixedWait = 0;
        applyStimulus(1'b0, AddrW'(0), 32'h0, 1'b0);
        applyStimulus(1'b0, AddrW'(4), 32'h0, 1'b0);
        applyStimulus(1'b0, AddrW'(8), 32'h0, 1'b0);
        checkOutput("rb_stb_before", 64'(bus.wb_stb_o), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rb_cyc", 64'(bus.wb_cyc_o), 64'd0);
        checkOutput("rb_stb", 64'(bus.wb_stb_o), 64'd0);
        checkOutput("rb_busy", 64'(bus.busy), 64'd0);
        checkOutput("rb_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        reset = 1'b0;
        expBusQ.delete();
        expRspQ.delete();
        start = rspCount;
        s0 = stbStarts;
        ackEnable = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rb_no_rsp", 64'(rspCount), 64'(start));
        checkOutput("rb_no_stb", 64'(stbStarts), 64'(s0));
        applyStimulus(1'b1, AddrW'(20), 32'h7777_1111, 1'b0);
        applyStimulus(1'b0, AddrW'(20), 32'h0, 1'b0);
        waitResponses(start + 2, "rb_after_wait");
        checkOutput("rb_after_rdata", 64'(lastRdata), 64'h7777_1111);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
